// File: rtl/crc_frame_arbiter_if.sv
// -----------------------------------------------------------------------------
// crc_frame_arbiter_if
//
// Purpose: carries the byte-stream handshake between two packet sources and
// the shared CRC arbiter. Requester i owns bit i of s_valid/s_last/s_ready and
// byte lane s_data[8i+7:8i].
//
// Signals:
//   s_valid [1:0]  per-requester byte valid
//   s_data  [15:0] per-requester byte, requester i on [8i+7:8i]
//   s_last  [1:0]  per-requester last-byte-of-frame flag, qualified by s_valid
//   s_ready [1:0]  per-requester accept
//
// Modports:
//   master : packet-source side (drives valid/data/last, observes ready)
//   slave  : arbiter side (observes valid/data/last, drives ready)
// -----------------------------------------------------------------------------
interface crc_frame_arbiter_if;
  logic [1:0]  s_valid;
  logic [15:0] s_data;
  logic [1:0]  s_last;
  logic [1:0]  s_ready;

  modport master (
    output s_valid,
    output s_data,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    output s_ready
  );
endinterface

// File: rtl/crc_frame_arbiter.sv
// -----------------------------------------------------------------------------
// crc_frame_arbiter
//
// Purpose: shares one bit-serial CRC-8 engine (poly x^8+x^2+x+1 = 0x07,
// MSB-first, init 0x00) between two byte-stream requesters. A whole frame is
// granted to one requester; each accepted byte is shifted through the engine
// one bit per clock, and the frame CRC is reported together with the owner's
// ID after the last byte has been shifted.
//
// Optional feature: define CRC_FINAL_XOR_EN to XOR the reported CRC with
// 8'h55 (CRC-8/ITU style). Without it the raw CRC register is reported.
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst        synchronous, active-high reset
//   s          crc_frame_arbiter_if.slave: s_valid/s_data/s_last in, s_ready out
//   busy       high whenever a frame is owned (any state but IDLE)
//   crc_out    frame CRC; valid with crc_valid, held until the next report
//   crc_id     requester that owned the reported frame; held like crc_out
//   crc_valid  one-cycle pulse per completed frame
//   state_dbg  current FSM state (0 IDLE, 1 SHIFT, 2 WAIT, 3 DONE)
//
// Handshake: a byte transfers on a rising edge where s_valid[i] && s_ready[i].
// A source must hold s_valid/s_data/s_last stable until the transfer. In IDLE
// s_ready is combinational from s_valid (the arbitration winner sees ready in
// the same cycle it raises valid); in WAIT s_ready[owner] is high regardless
// of s_valid; in SHIFT and DONE, and during reset, s_ready is 0.
//
// Timing: byte accepted in cycle T is shifted in T+1..T+8; the next byte of
// the frame can be taken at T+9 (WAIT). After the last byte, crc_valid is
// high in T+9 and the arbiter is back in IDLE at T+10.
// -----------------------------------------------------------------------------
module crc_frame_arbiter (
  input  logic                 clk,
  input  logic                 rst,
  crc_frame_arbiter_if.slave   s,
  output logic                 busy,
  output logic [7:0]           crc_out,
  output logic                 crc_id,
  output logic                 crc_valid,
  output logic [1:0]           state_dbg
);

  localparam logic [7:0] INIT = 8'h00;
  localparam logic [7:0] POLY = 8'h07;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // Frame context
  logic        owner;      // requester that owns the current frame
  logic        last_q;     // current byte closes the frame
  logic [7:0]  data_q;     // byte being shifted
  logic [2:0]  cnt;        // bit index within data_q, 0 = MSB
  logic [7:0]  crc_q;      // running CRC register
  logic        rr;         // round-robin pointer: preferred requester on a tie

  // Reported result, held between reports
  logic [7:0]  crc_out_q;
  logic        crc_id_q;

  // Arbitration and input selection
  logic        any_valid;
  logic        grant;
  logic        sel;
  logic [7:0]  byte_in;
  logic        last_in;
  logic        fire;

  // CRC step
  logic        feedback;
  logic [7:0]  crc_next;
  logic [7:0]  crc_final;

  // ---------------------------------------------------------------------------
  // Arbitration: a lone requester always wins; on a tie the round-robin
  // pointer decides.
  // ---------------------------------------------------------------------------
  assign any_valid = |s.s_valid;

  always_comb begin
    grant = rr;
    if (s.s_valid == 2'b01) begin
      grant = 1'b0;
    end else if (s.s_valid == 2'b10) begin
      grant = 1'b1;
    end
  end

  // In IDLE the incoming byte comes from the arbitration winner; otherwise
  // only the owner can be transferring.
  assign sel     = (state == IDLE) ? grant : owner;
  assign byte_in = sel ? s.s_data[15:8] : s.s_data[7:0];
  assign last_in = s.s_last[sel];
  assign fire    = |(s.s_valid & s.s_ready);

  // ---------------------------------------------------------------------------
  // One MSB-first CRC step per SHIFT cycle.
  // ---------------------------------------------------------------------------
  assign feedback = data_q[3'd7 - cnt] ^ crc_q[7];
  assign crc_next = {crc_q[6:0], 1'b0} ^ (feedback ? POLY : 8'h00);

`ifdef CRC_FINAL_XOR_EN
  localparam logic [7:0] XOR_OUT = 8'h55;
  assign crc_final = crc_next ^ XOR_OUT;
`else
  assign crc_final = crc_next;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (fire) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == 3'd7) begin
          state_nxt = last_q ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (fire) begin
          state_nxt = SHIFT;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. Ready is masked by rst so nothing looks accepted while the
  // block is held in reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    s.s_ready = 2'b00;
    busy      = 1'b0;
    crc_valid = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid && !rst) begin
          s.s_ready[grant] = 1'b1;
        end
      end
      SHIFT: begin
        busy = 1'b1;
      end
      WAIT: begin
        busy = 1'b1;
        if (!rst) begin
          s.s_ready[owner] = 1'b1;
        end
      end
      DONE: begin
        busy      = 1'b1;
        crc_valid = 1'b1;
      end
      default: begin
        s.s_ready = 2'b00;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: frame context, CRC register, round-robin pointer, result.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= 1'b0;
      last_q    <= 1'b0;
      data_q    <= 8'h00;
      cnt       <= 3'd0;
      crc_q     <= INIT;
      rr        <= 1'b0;
      crc_out_q <= 8'h00;
      crc_id_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fire) begin
            owner  <= grant;
            data_q <= byte_in;
            last_q <= last_in;
            crc_q  <= INIT;
            cnt    <= 3'd0;
          end
        end
        SHIFT: begin
          crc_q <= crc_next;
          cnt   <= cnt + 3'd1;
          // Capture the result on the final bit so it is already on crc_out
          // during the DONE cycle and stays there afterwards.
          if (cnt == 3'd7 && last_q) begin
            crc_out_q <= crc_final;
            crc_id_q  <= owner;
          end
        end
        WAIT: begin
          // Continuing byte: CRC register keeps accumulating, no reload.
          if (fire) begin
            data_q <= byte_in;
            last_q <= last_in;
            cnt    <= 3'd0;
          end
        end
        DONE: begin
          rr <= ~owner;
        end
        default: begin
          cnt <= 3'd0;
        end
      endcase
    end
  end

  assign crc_out   = crc_out_q;
  assign crc_id    = crc_id_q;
  assign state_dbg = state;

  // ---------------------------------------------------------------------------
  // Embedded checks: at most one requester is ever ready, and the report is a
  // single-cycle pulse.
  // ---------------------------------------------------------------------------
  a_ready_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(s.s_ready));

  a_valid_pulse: assert property (@(posedge clk) disable iff (rst)
    crc_valid |=> !crc_valid);

endmodule

// File: tb/tb_crc_frame_arbiter.sv
// -----------------------------------------------------------------------------
// tb_crc_frame_arbiter
//
// Directed bench for crc_frame_arbiter. Expected CRCs are hand-computed
// CRC-8 (0x07, init 0) values, optionally XORed with 8'h55 when
// CRC_FINAL_XOR_EN is defined:
//   0x01 -> 0x07, 0xFF -> 0xF3, "12" -> 0x72, "123456789" -> 0xF4
// -----------------------------------------------------------------------------
module tb_crc_frame_arbiter;

`ifdef CRC_FINAL_XOR_EN
  localparam logic [7:0] XM = 8'h55;
`else
  localparam logic [7:0] XM = 8'h00;
`endif

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  crc_frame_arbiter_if bus ();

  logic       busy;
  logic [7:0] crc_out;
  logic       crc_id;
  logic       crc_valid;
  logic [1:0] state_dbg;

  crc_frame_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .s         (bus),
    .busy      (busy),
    .crc_out   (crc_out),
    .crc_id    (crc_id),
    .crc_valid (crc_valid),
    .state_dbg (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];      // {id, crc}
  logic [8:0] obs_q[$];      // {id, crc} captured on each crc_valid
  int         obs_cyc_q[$];  // cycle count at each capture

  always @(negedge clk) begin
    if (crc_valid === 1'b1) begin
      obs_q.push_back({crc_id, crc_out});
      obs_cyc_q.push_back(cyc);
    end
  end

  task automatic clear_sb();
    exp_q.delete();
    obs_q.delete();
    obs_cyc_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.s_valid = 2'b00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Offer one byte on requester req; acc = cycle count right after transfer.
  task automatic send_byte(input int req, input logic [7:0] b, input logic last,
                           output int acc);
    int n;
    n = 0;
    acc = -1;
    @(negedge clk);
    bus.s_valid[req] = 1'b1;
    bus.s_data[req*8 +: 8] = b;
    bus.s_last[req] = last;
    #1;
    while (bus.s_ready[req] !== 1'b1 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: req %0d byte %h never accepted", req, b);
    end else begin
      @(posedge clk);
      #1;
      acc = cyc;
    end
    bus.s_valid[req] = 1'b0;
  endtask

  task automatic wait_pulses(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (obs_q.size() < n && k < budget) begin
      @(negedge clk);
      #2;
      k++;
    end
    ok = (obs_q.size() >= n);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (bus.s_ready !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b want 00", bus.s_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (crc_out !== 8'h00) begin errors++; $display("FAIL rst_crc_out: got %h want 00", crc_out); end
    checks++; if (crc_id !== 1'b0) begin errors++; $display("FAIL rst_crc_id: got %b want 0", crc_id); end
    checks++; if (crc_valid !== 1'b0) begin errors++; $display("FAIL rst_crc_valid: got %b want 0", crc_valid); end
    checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL rst_state: got %0d want 0", state_dbg); end
  endtask

  task automatic test_single_byte();
    int acc;
    bit ok;
    logic [8:0] e;
    clear_sb();
    send_byte(0, 8'h01, 1'b1, acc);
    exp_q.push_back({1'b0, 8'h07 ^ XM});
    wait_pulses(1, 20, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL single_pulse: got %0d pulses want 1", obs_q.size());
    end else begin
      e = exp_q.pop_front();
      checks++; if (obs_q[0] !== e) begin errors++; $display("FAIL single_crc: got %h want %h", obs_q[0], e); end
      checks++; if (obs_cyc_q[0] - acc != 8) begin errors++; $display("FAIL single_latency: got %0d want 8", obs_cyc_q[0] - acc); end
      @(negedge clk); #1;
      checks++; if (crc_valid !== 1'b0) begin errors++; $display("FAIL single_pulse_width: got %b want 0", crc_valid); end
      checks++; if (crc_out !== (8'h07 ^ XM)) begin errors++; $display("FAIL single_hold: got %h want %h", crc_out, 8'h07 ^ XM); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] str [9];
    int a [9];
    int bad;
    bit ok;
    logic [8:0] e;
    str = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    clear_sb();
    for (int i = 0; i < 9; i++) send_byte(1, str[i], (i == 8), a[i]);
    bad = 0;
    for (int i = 1; i < 9; i++) if (a[i] - a[i-1] != 9) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL b2b_spacing: got %0d gaps not 9 want 0", bad); end
    exp_q.push_back({1'b1, 8'hF4 ^ XM});
    wait_pulses(1, 20, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL b2b_pulse: got %0d pulses want 1", obs_q.size());
    end else begin
      e = exp_q.pop_front();
      checks++; if (obs_q[0] !== e) begin errors++; $display("FAIL b2b_crc: got %h want %h", obs_q[0], e); end
      checks++; if (obs_cyc_q[0] - a[8] != 8) begin errors++; $display("FAIL b2b_latency: got %0d want 8", obs_cyc_q[0] - a[8]); end
    end
  endtask

  task automatic test_contention();
    bit ok;
    logic [8:0] e;
    int bad;
    do_reset();
    clear_sb();
    @(negedge clk);
    bus.s_data  = 16'hFFFF;
    bus.s_last  = 2'b11;
    bus.s_valid = 2'b11;
    for (int i = 0; i < 4; i++) exp_q.push_back({i[0], 8'hF3 ^ XM});
    wait_pulses(4, 60, ok);
    bus.s_valid = 2'b00;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL rr_pulses: got %0d pulses want 4", obs_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        e = exp_q.pop_front();
        checks++; if (obs_q[i] !== e) begin errors++; $display("FAIL rr_frame%0d: got %h want %h", i, obs_q[i], e); end
      end
      bad = 0;
      for (int i = 1; i < 4; i++) if (obs_cyc_q[i] - obs_cyc_q[i-1] != 10) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL rr_spacing: got %0d gaps not 10 want 0", bad); end
    end
  endtask

  task automatic test_non_owner_blocked();
    int a0, a1, acc1, k;
    bit viol, seen, ok;
    logic [8:0] e;
    do_reset();
    clear_sb();
    send_byte(0, 8'h31, 1'b0, a0);
    @(negedge clk);
    bus.s_valid[1] = 1'b1;
    bus.s_data[15:8] = 8'h01;
    bus.s_last[1] = 1'b1;
    viol = 1'b0;
    seen = 1'b0;
    fork
      send_byte(0, 8'h32, 1'b1, a1);
      begin
        k = 0;
        while (!seen && k < 40) begin
          @(negedge clk); #1;
          if (bus.s_ready[1] !== 1'b0) viol = 1'b1;
          if (crc_valid === 1'b1) seen = 1'b1;
          k++;
        end
      end
    join
    checks++; if (viol) begin errors++; $display("FAIL block_ready1: got ready[1]=1 before done want 0"); end
    checks++; if (!seen) begin errors++; $display("FAIL block_done: got no done want done"); end
    @(posedge clk); #1;
    checks++; if (bus.s_ready !== 2'b10) begin errors++; $display("FAIL block_next_grant: got %b want 10", bus.s_ready); end
    @(posedge clk); #1;
    acc1 = cyc;
    bus.s_valid[1] = 1'b0;
    exp_q.push_back({1'b0, 8'h72 ^ XM});
    exp_q.push_back({1'b1, 8'h07 ^ XM});
    wait_pulses(2, 20, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL block_pulses: got %0d pulses want 2", obs_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        e = exp_q.pop_front();
        checks++; if (obs_q[i] !== e) begin errors++; $display("FAIL block_frame%0d: got %h want %h", i, obs_q[i], e); end
      end
      checks++; if (obs_cyc_q[1] - acc1 != 8) begin errors++; $display("FAIL block_latency: got %0d want 8", obs_cyc_q[1] - acc1); end
    end
  endtask

  task automatic test_owner_pause();
    logic [7:0] str [9];
    int acc;
    bit ok;
    logic [8:0] e;
    str = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    clear_sb();
    send_byte(0, str[0], 1'b0, acc);
    repeat (20) @(negedge clk);
    #1;
    checks++; if (state_dbg !== ST_WAIT || bus.s_ready !== 2'b01 || busy !== 1'b1) begin
      errors++; $display("FAIL pause_wait: got state %0d ready %b busy %b want 2 01 1", state_dbg, bus.s_ready, busy);
    end
    for (int i = 1; i < 9; i++) send_byte(0, str[i], (i == 8), acc);
    exp_q.push_back({1'b0, 8'hF4 ^ XM});
    wait_pulses(1, 20, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL pause_pulse: got %0d pulses want 1", obs_q.size());
    end else begin
      e = exp_q.pop_front();
      checks++; if (obs_q[0] !== e) begin errors++; $display("FAIL pause_crc: got %h want %h", obs_q[0], e); end
    end
  endtask

  task automatic test_mid_reset();
    int acc;
    bit ok;
    logic [8:0] e;
    clear_sb();
    send_byte(0, 8'hA5, 1'b1, acc);
    repeat (4) @(posedge clk);
    #1;
    checks++; if (state_dbg !== ST_SHIFT || busy !== 1'b1) begin
      errors++; $display("FAIL mid_pre: got state %0d busy %b want 1 1", state_dbg, busy);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || crc_valid !== 1'b0 || crc_out !== 8'h00 || crc_id !== 1'b0 ||
                  bus.s_ready !== 2'b00 || state_dbg !== ST_IDLE) begin
      errors++; $display("FAIL mid_rst_outputs: got busy %b v %b crc %h id %b rdy %b st %0d want 0 0 00 0 00 0",
                         busy, crc_valid, crc_out, crc_id, bus.s_ready, state_dbg);
    end
    rst = 1'b0;
    repeat (12) @(negedge clk);
    #2;
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL mid_no_pulse: got %0d pulses want 0", obs_q.size()); end
    clear_sb();
    send_byte(1, 8'h01, 1'b1, acc);
    exp_q.push_back({1'b1, 8'h07 ^ XM});
    wait_pulses(1, 20, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL mid_after_pulse: got %0d pulses want 1", obs_q.size());
    end else begin
      e = exp_q.pop_front();
      checks++; if (obs_q[0] !== e) begin errors++; $display("FAIL mid_after_crc: got %h want %h", obs_q[0], e); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.s_valid = 2'b00;
    bus.s_data  = 16'h0000;
    bus.s_last  = 2'b00;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_contention();
    test_non_owner_blocked();
    test_owner_pause();
    test_mid_reset();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so a stuck handshake can never hang the run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/crc_frame_arbiter.md
# crc_frame_arbiter

Shares one bit-serial CRC-8 engine (polynomial x^8+x^2+x+1, 0x07, MSB-first) between two byte-stream requesters. The arbiter grants a whole frame to one requester, serializes each accepted byte into the engine one bit per clock, and reports the frame CRC with the owner's ID when the frame's last byte has been shifted. It sits between packet sources and the link framer, replacing per-source CRC engines.

## Interface
- INIT, 8'h00, CRC register value loaded at the start of every frame
- XOR_OUT, 8'h55, final XOR mask applied to the result (used only with CRC_FINAL_XOR_EN)
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- s_valid  input  2  per-requester byte valid; bit i belongs to requester i
- s_data  input  16  per-requester byte; requester i on [8i+7:8i]
- s_last  input  2  per-requester last-byte-of-frame flag, qualified by s_valid
- s_ready  output  2  per-requester accept; byte transfers when s_valid[i] && s_ready[i]
- busy  output  1  high whenever a frame is owned (any state but IDLE)
- crc_out  output  8  frame CRC, valid while crc_valid is high
- crc_id  output  1  requester that owned the reported frame
- crc_valid  output  1  one-cycle pulse per completed frame

## Operation
- States: IDLE (no owner), SHIFT (8 bit cycles), WAIT (owner holds frame, no byte pending), DONE (report).
- IDLE: if exactly one s_valid set, grant it; if both, grant the round-robin pointer's requester. s_ready[grant] driven combinationally high in the same cycle (depends on s_valid); byte accepted, owner and s_last latched, CRC register loaded with INIT, go SHIFT.
- SHIFT: bit counter 0..7; each cycle feedback = data[7-cnt] ^ crc[7]; crc = {crc[6:0],0} ^ (feedback ? 8'h07 : 0). At cnt 7: latched last -> DONE, else -> WAIT. s_ready = 0 throughout.
- WAIT: s_ready[owner] = 1, s_ready[other] = 0. On owner transfer: latch byte and s_last, go SHIFT (CRC not reloaded). Owner may idle indefinitely; non-owner requests are ignored until frame ends.
- DONE: crc_valid = 1, crc_out = final CRC, crc_id = owner; round-robin pointer set to the non-owner; next state IDLE.
- Round-robin pointer resets to requester 0.
- Single-byte frame (s_last on first byte) is legal: IDLE -> SHIFT -> DONE.
- Reset mid-frame: state IDLE, partial CRC discarded, no crc_valid pulse.

## Timing
- Reset values: s_ready 0 (combinational, no s_valid), busy 0, crc_out 8'h00, crc_id 0, crc_valid 0, pointer 0.
- Byte accepted in cycle T -> bits shifted in T+1..T+8 -> next byte acceptable earliest T+9 (WAIT). Max throughput one byte per 9 cycles.
- Last byte accepted in T -> crc_valid high in T+9 exactly; IDLE in T+10, earliest next frame acceptance T+10.
- crc_out and crc_id hold their value after the pulse until the next DONE.
- busy high from T+1 after first acceptance through the DONE cycle inclusive.

## Configuration
- CRC_FINAL_XOR_EN defined: crc_out = CRC register ^ XOR_OUT (CRC-8/ITU-style).
- Not defined: crc_out = raw CRC register; XOR_OUT unused.

## Test plan
- Reset, requester 0 sends single byte 0x01 with s_last -> crc_valid one cycle 9 cycles after accept, crc_out 0x07, crc_id 0 (macro off).
- Requester 1 sends "123456789" (0x31..0x39), last on 0x39, back-to-back -> accepts every 9 cycles, crc_out 0xF4, crc_id 1; with CRC_FINAL_XOR_EN and XOR_OUT 0x55 -> 0xA1.
- Both s_valid held from reset, one-byte frames 0xFF each -> grants alternate 0,1,0,1; each crc_out 0xF3.
- During requester 0's frame, requester 1 asserts s_valid -> s_ready[1] stays 0 until requester 0's DONE; requester 1 granted next in IDLE.
- Owner drops s_valid for 20 cycles in WAIT between bytes 0x31 and 0x32... -> CRC unchanged vs. back-to-back run (0xF4 for full string).
- rst asserted at SHIFT cnt 4 of a frame -> next cycle all outputs at reset values, no crc_valid; new frame 0x01 then yields 0x07.
